pwm_deadtime_gen: RTL and testbench

//  Dead-time insertion stage, directly downstream of the PWM carrier/comparator.

---
 rtl/pwm_deadtime_gen.sv | 166 ++++++++++++++++
 tb/tb_pwm_deadtime_gen.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_deadtime_gen.sv
// ---------------------------------------------------------------------------
// pwm_deadtime_gen
//   Dead-time insertion stage that sits after the PWM carrier/comparator.
//   It turns one raw PWM compare bit into a complementary high-side/low-side
//   gate pair. The two gates are never on together. Every hand-over passes
//   through a dead interval of a programmable number of i_ce ticks. A dead
//   interval of zero ticks means a direct swap.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active high
//   i_ce       count-enable tick from the clock divider (dead-time timebase)
//   i_onoff    1 = PWM_ON, 0 = PWM_OFF (forces both gates low)
//   i_pwm      raw PWM, 1 = high side requested
//   i_dt_rise  dead ticks between low-side off and high-side on
//   i_dt_fall  dead ticks between high-side off and low-side on
//   o_pwm_h    high-side gate (registered)
//   o_pwm_l    low-side gate (registered)
//   o_dt_busy  1 while a dead interval is being timed (registered)
// ---------------------------------------------------------------------------
module pwm_deadtime_gen #(
   parameter int DT_WIDTH = 7
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_ce,
   input  logic                i_onoff,
   input  logic                i_pwm,
   input  logic [DT_WIDTH-1:0] i_dt_rise,
   input  logic [DT_WIDTH-1:0] i_dt_fall,
   output logic                o_pwm_h,
   output logic                o_pwm_l,
   output logic                o_dt_busy
);

   typedef enum logic [2:0] {
      S_OFF   = 3'd0,
      S_HIGH  = 3'd1,
      S_DT_HL = 3'd2,
      S_LOW   = 3'd3,
      S_DT_LH = 3'd4
   } state_t;

   state_t              state, state_nxt;
   logic [DT_WIDTH-1:0] cnt, cnt_nxt;
   logic                h_nxt, l_nxt, busy_nxt;

   logic rise_zero, fall_zero;
   assign rise_zero = (i_dt_rise == '0);
   assign fall_zero = (i_dt_fall == '0);

   // Next-state and next-count logic. The dead-time value is copied into the
   // counter only on the transition into a dead state. After that, changes on
   // i_dt_* have no effect on an interval that is already running.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;

      if (!i_onoff) begin
         state_nxt = S_OFF;
         cnt_nxt   = '0;
      end else begin
         case (state)
            S_OFF: begin
               // Always pass through a dead interval on enable: the previous
               // gate state of the power stage is not known here.
               if (i_pwm) begin
                  if (rise_zero) state_nxt = S_HIGH;
                  else begin
                     state_nxt = S_DT_LH;
                     cnt_nxt   = i_dt_rise;
                  end
               end else begin
                  if (fall_zero) state_nxt = S_LOW;
                  else begin
                     state_nxt = S_DT_HL;
                     cnt_nxt   = i_dt_fall;
                  end
               end
            end

            S_LOW: begin
               if (i_pwm) begin
                  if (rise_zero) state_nxt = S_HIGH;
                  else begin
                     state_nxt = S_DT_LH;
                     cnt_nxt   = i_dt_rise;
                  end
               end
            end

            S_HIGH: begin
               if (!i_pwm) begin
                  if (fall_zero) state_nxt = S_LOW;
                  else begin
                     state_nxt = S_DT_HL;
                     cnt_nxt   = i_dt_fall;
                  end
               end
            end

            S_DT_LH: begin
               // Abort takes priority over expiry. The high side has not
               // turned on yet, so going straight back to low is safe.
               if (!i_pwm) begin
                  state_nxt = S_LOW;
                  cnt_nxt   = '0;
               end else if (i_ce) begin
                  if (cnt <= DT_WIDTH'(1)) begin
                     state_nxt = S_HIGH;
                     cnt_nxt   = '0;
                  end else begin
                     cnt_nxt = cnt - DT_WIDTH'(1);
                  end
               end
            end

            S_DT_HL: begin
               if (i_pwm) begin
                  state_nxt = S_HIGH;
                  cnt_nxt   = '0;
               end else if (i_ce) begin
                  if (cnt <= DT_WIDTH'(1)) begin
                     state_nxt = S_LOW;
                     cnt_nxt   = '0;
                  end else begin
                     cnt_nxt = cnt - DT_WIDTH'(1);
                  end
               end
            end

            default: begin
               state_nxt = S_OFF;
               cnt_nxt   = '0;
            end
         endcase
      end
   end

   // The outputs are decoded from the next state and registered together
   // with it. This gives one clock of latency from the input to the gate
   // change. Because the decode is one-hot on the state, h and l can never
   // be high at the same time.
   always_comb begin
      h_nxt    = (state_nxt == S_HIGH);
      l_nxt    = (state_nxt == S_LOW);
      busy_nxt = (state_nxt == S_DT_LH) || (state_nxt == S_DT_HL);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_OFF;
         cnt       <= '0;
         o_pwm_h   <= 1'b0;
         o_pwm_l   <= 1'b0;
         o_dt_busy <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         o_pwm_h   <= h_nxt;
         o_pwm_l   <= l_nxt;
         o_dt_busy <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// ---------------------------------------------------------------------------
// tb_pwm_deadtime_gen
//   Bench for pwm_deadtime_gen. The reference model describes behaviour only
//   in terms of which side is wanted and how many ticks of dead time remain.
// ---------------------------------------------------------------------------
module tb_pwm_deadtime_gen;

   localparam int DW = 7;

   logic          clk = 1'b0;
   logic          rst, ce, onoff, pwm;
   logic [DW-1:0] dt_rise, dt_fall;
   logic          pwm_h, pwm_l, dt_busy;

   int checks = 0;
   int errors = 0;

   // reference model
   bit m_on, m_tgt;
   int m_left;
   bit exp_h, exp_l, exp_busy;

   pwm_deadtime_gen #(.DT_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .i_ce(ce), .i_onoff(onoff), .i_pwm(pwm),
      .i_dt_rise(dt_rise), .i_dt_fall(dt_fall),
      .o_pwm_h(pwm_h), .o_pwm_l(pwm_l), .o_dt_busy(dt_busy)
   );

   always #5 clk = ~clk;

   // Model rules: once enabled, the gate follows the wanted side after a
   // dead interval of N ticks. A change of the wanted side while the
   // interval is running cancels it and returns to the side that was on.
   task automatic model_step();
      if (rst) begin
         m_on = 0; m_tgt = 0; m_left = 0;
      end else if (!onoff) begin
         m_on = 0; m_left = 0;
      end else if (!m_on) begin
         m_on = 1; m_tgt = pwm; m_left = pwm ? int'(dt_rise) : int'(dt_fall);
      end else if (pwm != m_tgt) begin
         if (m_left == 0) m_left = pwm ? int'(dt_rise) : int'(dt_fall);
         else             m_left = 0;
         m_tgt = pwm;
      end else if (m_left > 0 && ce) begin
         m_left = m_left - 1;
      end
      exp_h    = m_on && (m_left == 0) && m_tgt;
      exp_l    = m_on && (m_left == 0) && !m_tgt;
      exp_busy = m_on && (m_left != 0);
   endtask

   // one clock: inputs are held across the edge, outputs are settled at +1
   task automatic cyc();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic go_low();
      int k;
      pwm = 0; ce = 1; onoff = 1;
      for (k = 0; k < 300; k++) begin
         cyc();
         if (pwm_l) break;
      end
      if (k == 300) begin
         errors++;
         $display("FAIL go_low timeout: l=%0b wanted 1", pwm_l);
      end
   endtask

   task automatic test_reset();
      int k;
      rst = 1; onoff = 1; pwm = 0; ce = 1; dt_rise = 4; dt_fall = 5;
      repeat (3) cyc();
      checks++;
      if ({pwm_h, pwm_l, dt_busy} !== 3'b000) begin
         errors++;
         $display("FAIL reset_outputs: h/l/busy=%b wanted 000", {pwm_h, pwm_l, dt_busy});
      end
      rst = 0;
      cyc();
      checks++;
      if ({pwm_h, pwm_l, dt_busy} !== 3'b001) begin
         errors++;
         $display("FAIL enable_entry: h/l/busy=%b wanted 001", {pwm_h, pwm_l, dt_busy});
      end
      for (k = 1; k <= 50; k++) begin
         cyc();
         if (pwm_l) break;
      end
      checks++;
      if (k != 5) begin
         errors++;
         $display("FAIL enable_gap: l rose after %0d cycles wanted 5", k);
      end
   endtask

   task automatic test_pwm_period();
      int k;
      dt_rise = 4; dt_fall = 6; ce = 1;
      go_low();
      for (int p = 0; p < 2; p++) begin
         pwm = 1;
         cyc();
         checks++;
         if (pwm_l !== 1'b0 || pwm_h !== 1'b0) begin
            errors++;
            $display("FAIL period_l_fall: h=%b l=%b wanted 0 0", pwm_h, pwm_l);
         end
         for (k = 1; k < 20; k++) begin
            cyc();
            if (pwm_h) break;
         end
         checks++;
         if (k != 4) begin
            errors++;
            $display("FAIL period_rise_gap: h rose after %0d wanted 4", k);
         end
         for (int j = k; j < 19; j++) begin
            cyc();
            checks++;
            if (pwm_h !== 1'b1 || pwm_l !== 1'b0) begin
               errors++;
               $display("FAIL period_high_hold: h=%b l=%b wanted 1 0", pwm_h, pwm_l);
            end
         end
         pwm = 0;
         cyc();
         checks++;
         if (pwm_h !== 1'b0 || pwm_l !== 1'b0) begin
            errors++;
            $display("FAIL period_h_fall: h=%b l=%b wanted 0 0", pwm_h, pwm_l);
         end
         for (k = 1; k < 20; k++) begin
            cyc();
            if (pwm_l) break;
         end
         checks++;
         if (k != 6) begin
            errors++;
            $display("FAIL period_fall_gap: l rose after %0d wanted 6", k);
         end
         for (int j = k; j < 19; j++) cyc();
      end
   endtask

   task automatic test_ce_div();
      int found;
      dt_rise = 3; dt_fall = 2;
      go_low();
      pwm = 1; ce = 0;
      cyc();
      found = 0;
      for (int k = 1; k <= 40; k++) begin
         ce = (k % 4 == 0);
         if (k == 5) dt_rise = 10;
         cyc();
         if (pwm_h && found == 0) found = k;
      end
      checks++;
      if (found != 12) begin
         errors++;
         $display("FAIL ce_div_gap: h rose after %0d clk wanted 12", found);
      end
   endtask

   task automatic test_abort();
      int hseen;
      dt_rise = 8; dt_fall = 2;
      go_low();
      pwm = 1;
      for (int k = 0; k < 3; k++) begin
         cyc();
         checks++;
         if ({pwm_h, pwm_l, dt_busy} !== 3'b001) begin
            errors++;
            $display("FAIL abort_dead: h/l/busy=%b wanted 001", {pwm_h, pwm_l, dt_busy});
         end
      end
      pwm = 0;
      cyc();
      checks++;
      if ({pwm_h, pwm_l, dt_busy} !== 3'b010) begin
         errors++;
         $display("FAIL abort_return: h/l/busy=%b wanted 010", {pwm_h, pwm_l, dt_busy});
      end
      hseen = 0;
      repeat (10) begin
         cyc();
         if (pwm_h) hseen = 1;
      end
      checks++;
      if (hseen != 0) begin
         errors++;
         $display("FAIL abort_no_high: h seen=%0d wanted 0", hseen);
      end
   endtask

   task automatic test_onoff();
      int k;
      dt_rise = 3; dt_fall = 2;
      for (int pass = 0; pass < 2; pass++) begin
         go_low();
         pwm = 1;
         cyc();
         if (pass == 0) repeat (5) cyc();
         onoff = 0;
         cyc();
         checks++;
         if ({pwm_h, pwm_l, dt_busy} !== 3'b000) begin
            errors++;
            $display("FAIL onoff_off_%0d: h/l/busy=%b wanted 000", pass, {pwm_h, pwm_l, dt_busy});
         end
         onoff = 1; pwm = 1;
         cyc();
         for (k = 1; k < 20; k++) begin
            cyc();
            if (pwm_h) break;
         end
         checks++;
         if (k != 3) begin
            errors++;
            $display("FAIL onoff_reenable_%0d: h rose after %0d wanted 3", pass, k);
         end
      end
   endtask

   task automatic test_zero_dt();
      dt_rise = 0; dt_fall = 0;
      go_low();
      for (int k = 0; k < 4; k++) begin
         pwm = 1;
         cyc();
         checks++;
         if ({pwm_h, pwm_l, dt_busy} !== 3'b100) begin
            errors++;
            $display("FAIL zero_dt_rise: h/l/busy=%b wanted 100", {pwm_h, pwm_l, dt_busy});
         end
         pwm = 0;
         cyc();
         checks++;
         if ({pwm_h, pwm_l, dt_busy} !== 3'b010) begin
            errors++;
            $display("FAIL zero_dt_fall: h/l/busy=%b wanted 010", {pwm_h, pwm_l, dt_busy});
         end
      end
   endtask

   task automatic test_random();
      int bad = 0;
      rst = 1;
      cyc();
      rst = 0;
      for (int n = 0; n < 10000; n++) begin
         if ($urandom_range(7) == 0)   pwm = ~pwm;
         ce = ($urandom_range(2) != 0);
         if ($urandom_range(31) == 0)  dt_rise = DW'($urandom_range(15));
         if ($urandom_range(31) == 0)  dt_fall = DW'($urandom_range(15));
         onoff = ($urandom_range(99) != 0);
         rst   = ($urandom_range(499) == 0);
         cyc();
         checks++;
         if ({pwm_h, pwm_l, dt_busy} !== {exp_h, exp_l, exp_busy} || (pwm_h & pwm_l)) begin
            errors++;
            if (bad < 10)
               $display("FAIL random_cyc%0d: h/l/busy=%b wanted %b", n,
                        {pwm_h, pwm_l, dt_busy}, {exp_h, exp_l, exp_busy});
            bad++;
         end
      end
      rst = 0;
   endtask

   initial begin
      rst = 1; ce = 0; onoff = 0; pwm = 0; dt_rise = '0; dt_fall = '0;
      test_reset();
      test_pwm_period();
      test_ce_div();
      test_abort();
      test_onoff();
      test_zero_dt();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
